// File: rtl/dc_write_buffer_pkg.sv
// Shared constants, entry layout and byte-merge helper for the DCache store buffer.
// Also the single source of the buffer depth and line offset used by the refill logic.
package dc_write_buffer_pkg;

    localparam int WB_DEPTH   = 8;
    localparam int LINE_OFF_W = 4;
    localparam int WADDR_W    = 30;
    localparam int LINE_W     = 32 - LINE_OFF_W;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [3:0]         strb;
        logic [31:0]        data;
    } wb_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [LINE_W-1:0] line_of_word(input logic [WADDR_W-1:0] waddr);
        return waddr[WADDR_W-1:LINE_OFF_W-2];
    endfunction

endpackage

// File: rtl/dc_write_buffer_if.sv
// Store-side, hazard-lookup and AXI-write-port signals of the DCache write buffer.
// The buffer takes the slave view; the DCache/AXI side (or a bench) takes master.
interface dc_write_buffer_if;

    logic [3:0]  cpu_wen;
    logic [31:0] cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        cpu_wrdy;
    logic [31:0] lk_addr;
    logic        lk_conflict;
    logic        wb_idle;
    logic        dc_dev_wrdy;
    logic [3:0]  dc_cpu_wen;
    logic [31:0] dc_cpu_waddr;
    logic [31:0] dc_cpu_wdata;

    modport slave (
        input  cpu_wen, cpu_waddr, cpu_wdata, lk_addr, dc_dev_wrdy,
        output cpu_wrdy, lk_conflict, wb_idle, dc_cpu_wen, dc_cpu_waddr, dc_cpu_wdata
    );

    modport master (
        output cpu_wen, cpu_waddr, cpu_wdata, lk_addr, dc_dev_wrdy,
        input  cpu_wrdy, lk_conflict, wb_idle, dc_cpu_wen, dc_cpu_waddr, dc_cpu_wdata
    );

endinterface

// File: rtl/dc_write_buffer_wb_cam_match.sv
// DEPTH-way line-address comparator: any valid entry or the in-flight store
// sharing the lookup's cache line raises hit_o.
module wb_cam_match #(
    parameter int DEPTH  = 8,
    parameter int LINE_W = 28
) (
    input  logic [DEPTH-1:0][LINE_W-1:0] entry_line_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [LINE_W-1:0]            inflight_line_i,
    input  logic                         inflight_i,
    input  logic [LINE_W-1:0]            lk_line_i,
    output logic                         hit_o
);

    logic [DEPTH-1:0] way_hit;

    always_comb begin
        way_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            way_hit[i] = valid_i[i] && (entry_line_i[i] == lk_line_i);
        end
    end

    assign hit_o = (|way_hit) || (inflight_i && (inflight_line_i == lk_line_i));

endmodule

// File: rtl/dc_write_buffer.sv
// Word store buffer in front of the AXI master's single-beat DCache write port.
// Merges stores into the newest entry and flags line-granular read-after-write hazards.
module dc_write_buffer
    import dc_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             aresetn,
    dc_write_buffer_if.slave bus
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [LINE_W-1:0]  inflight_line_q, inflight_line_d;

    logic               full, empty, push, pop, merge, alloc;
    logic [PTR_W-1:0]   newest;
    logic [PTR_W-1:0]   off;
    wb_entry_t          head_entry;
    wb_entry_t          new_entry;
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0][LINE_W-1:0] entry_line;
    logic               unused_addr_bits;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign newest     = tail_q - PTR_ONE;
    assign head_entry = mem_q[head_q];

    // A full buffer refuses stores even when the head drains the same cycle,
    // keeping cpu_wrdy a pure function of registers.
    assign push  = (bus.cpu_wen != 4'h0) && !full;
    assign pop   = bus.dc_dev_wrdy && !empty;
    assign merge = push && !empty
                && (mem_q[newest].addr == bus.cpu_waddr[31:2])
                && !(pop && (head_q == newest));
    assign alloc = push && !merge;

    assign new_entry.addr = bus.cpu_waddr[31:2];
    assign new_entry.strb = bus.cpu_wen;
    assign new_entry.data = bus.cpu_wdata;

    always_comb begin
        head_d          = pop   ? head_q + PTR_ONE : head_q;
        tail_d          = alloc ? tail_q + PTR_ONE : tail_q;
        count_d         = count_q;
        inflight_d      = inflight_q;
        inflight_line_d = inflight_line_q;
        case ({alloc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (pop) begin
            inflight_d      = 1'b1;
            inflight_line_d = line_of_word(head_entry.addr);
        end else if (bus.dc_dev_wrdy) begin
            inflight_d      = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_line_q <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_line_q <= inflight_line_d;
        end
    end

    // Entry payload needs no reset: validity comes from head/count alone.
    always_ff @(posedge aclk) begin
        if (alloc) begin
            mem_q[tail_q] <= new_entry;
        end else if (merge) begin
            mem_q[newest].strb <= mem_q[newest].strb | bus.cpu_wen;
            mem_q[newest].data <= merge_bytes(mem_q[newest].data, bus.cpu_wdata, bus.cpu_wen);
        end
    end

    always_comb begin
        valid      = '0;
        off        = '0;
        entry_line = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PTR_W'(i) - head_q;
            valid[i]      = ({1'b0, off} < count_q);
            entry_line[i] = line_of_word(mem_q[i].addr);
        end
    end

    wb_cam_match #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_cam (
        .entry_line_i    (entry_line),
        .valid_i         (valid),
        .inflight_line_i (inflight_line_q),
        .inflight_i      (inflight_q),
        .lk_line_i       (line_of_word(bus.lk_addr[31:2])),
        .hit_o           (bus.lk_conflict)
    );

    // Outputs read as zero while empty so stale payload never leaks downstream.
    assign bus.cpu_wrdy     = !full;
    assign bus.wb_idle      = empty && !inflight_q;
    assign bus.dc_cpu_wen   = empty ? 4'h0  : head_entry.strb;
    assign bus.dc_cpu_waddr = empty ? 32'h0 : {head_entry.addr, 2'b00};
    assign bus.dc_cpu_wdata = empty ? 32'h0 : head_entry.data;

    assign unused_addr_bits = ^{bus.cpu_waddr[1:0], bus.lk_addr[1:0]};

endmodule

// File: tb/tb_dc_write_buffer.sv
// Directed bench for dc_write_buffer: latency, merge, full/wrap, hazards, push+pop, reset.
module tb_dc_write_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    dc_write_buffer_if bus();

    dc_write_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic store(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_wen = wen; bus.cpu_waddr = addr; bus.cpu_wdata = data;
    endtask

    task automatic drain();
        bus.dc_dev_wrdy = 1'b1;
        for (int n = 0; n < 40 && !bus.wb_idle; n++) @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL drain_idle got=%b exp=1", bus.wb_idle); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.cpu_wrdy !== 1'b1) begin errors++; $display("FAIL rst_wrdy got=%b exp=1", bus.cpu_wrdy); end
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL rst_wen got=%h exp=0", bus.dc_cpu_wen); end
        checks++; if (bus.dc_cpu_waddr !== 32'h0) begin errors++; $display("FAIL rst_waddr got=%h exp=0", bus.dc_cpu_waddr); end
        checks++; if (bus.dc_cpu_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.dc_cpu_wdata); end
        checks++; if (bus.lk_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict got=%b exp=0", bus.lk_conflict); end
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", bus.wb_idle); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b1;
        store(4'hF, 32'h100, 32'hAABBCCDD);
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        checks++; if (bus.dc_cpu_wen !== 4'hF) begin errors++; $display("FAIL single_wen got=%h exp=f", bus.dc_cpu_wen); end
        checks++; if (bus.dc_cpu_waddr !== 32'h100) begin errors++; $display("FAIL single_addr got=%h exp=100", bus.dc_cpu_waddr); end
        checks++; if (bus.dc_cpu_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL single_data got=%h exp=aabbccdd", bus.dc_cpu_wdata); end
        checks++; if (bus.wb_idle !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", bus.wb_idle); end
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL single_popped got=%h exp=0", bus.dc_cpu_wen); end
        checks++; if (bus.wb_idle !== 1'b0) begin errors++; $display("FAIL single_inflight got=%b exp=0", bus.wb_idle); end
        @(negedge clk);
        checks++; if (bus.wb_idle !== 1'b0) begin errors++; $display("FAIL single_inflight_hold got=%b exp=0", bus.wb_idle); end
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", bus.wb_idle); end
    endtask

    task automatic test_merge();
        @(negedge clk);
        store(4'h1, 32'h200, 32'h11);
        @(negedge clk);
        store(4'h4, 32'h202, 32'h00220000);
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        checks++; if (bus.dc_cpu_wen !== 4'h5) begin errors++; $display("FAIL merge_strb got=%h exp=5", bus.dc_cpu_wen); end
        checks++; if (bus.dc_cpu_waddr !== 32'h200) begin errors++; $display("FAIL merge_addr got=%h exp=200", bus.dc_cpu_waddr); end
        checks++; if (bus.dc_cpu_wdata !== 32'h00220011) begin errors++; $display("FAIL merge_data got=%h exp=00220011", bus.dc_cpu_wdata); end
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL merge_count1 got=%h exp=0", bus.dc_cpu_wen); end
        drain();
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            store(4'hF, 32'h400 + 32'(4*i), 32'h1000 + 32'(i));
        end
        @(negedge clk);
        checks++; if (bus.cpu_wrdy !== 1'b0) begin errors++; $display("FAIL full_wrdy got=%b exp=0", bus.cpu_wrdy); end
        store(4'hF, 32'h420, 32'h1008);
        @(negedge clk);
        checks++; if (bus.cpu_wrdy !== 1'b0) begin errors++; $display("FAIL full_held got=%b exp=0", bus.cpu_wrdy); end
        checks++; if (bus.dc_cpu_waddr !== 32'h400) begin errors++; $display("FAIL full_head got=%h exp=400", bus.dc_cpu_waddr); end
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.cpu_wrdy !== 1'b1) begin errors++; $display("FAIL full_pop_frees got=%b exp=1", bus.cpu_wrdy); end
        checks++; if (bus.dc_cpu_waddr !== 32'h404) begin errors++; $display("FAIL full_head2 got=%h exp=404", bus.dc_cpu_waddr); end
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        checks++; if (bus.cpu_wrdy !== 1'b0) begin errors++; $display("FAIL full_ninth_in got=%b exp=0", bus.cpu_wrdy); end
        bus.dc_dev_wrdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.dc_cpu_waddr !== 32'h404 + 32'(4*k)) begin errors++; $display("FAIL wrap_order_addr k=%0d got=%h exp=%h", k, bus.dc_cpu_waddr, 32'h404 + 32'(4*k)); end
            checks++; if (bus.dc_cpu_wdata !== 32'h1001 + 32'(k)) begin errors++; $display("FAIL wrap_order_data k=%0d got=%h exp=%h", k, bus.dc_cpu_wdata, 32'h1001 + 32'(k)); end
            @(negedge clk);
        end
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL wrap_idle got=%b exp=1", bus.wb_idle); end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        store(4'hF, 32'h304, 32'hCAFE);
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        bus.lk_addr = 32'h30C; #1;
        checks++; if (bus.lk_conflict !== 1'b1) begin errors++; $display("FAIL cf_same_line got=%b exp=1", bus.lk_conflict); end
        bus.lk_addr = 32'h310; #1;
        checks++; if (bus.lk_conflict !== 1'b0) begin errors++; $display("FAIL cf_next_line got=%b exp=0", bus.lk_conflict); end
        bus.lk_addr = 32'h300; #1;
        checks++; if (bus.lk_conflict !== 1'b1) begin errors++; $display("FAIL cf_line_base got=%b exp=1", bus.lk_conflict); end
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        bus.lk_addr = 32'h30C; #1;
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL cf_popped got=%h exp=0", bus.dc_cpu_wen); end
        checks++; if (bus.lk_conflict !== 1'b1) begin errors++; $display("FAIL cf_inflight got=%b exp=1", bus.lk_conflict); end
        @(negedge clk);
        checks++; if (bus.lk_conflict !== 1'b1) begin errors++; $display("FAIL cf_inflight_hold got=%b exp=1", bus.lk_conflict); end
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.lk_conflict !== 1'b0) begin errors++; $display("FAIL cf_cleared got=%b exp=0", bus.lk_conflict); end
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL cf_idle got=%b exp=1", bus.wb_idle); end
        bus.lk_addr = 32'h0;
    endtask

    task automatic test_no_merge_on_pop();
        @(negedge clk);
        store(4'h1, 32'h600, 32'h11);
        @(negedge clk);
        store(4'h2, 32'h600, 32'h2200);
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        bus.dc_dev_wrdy = 1'b0;
        checks++; if (bus.dc_cpu_wen !== 4'h2) begin errors++; $display("FAIL nomerge_strb got=%h exp=2", bus.dc_cpu_wen); end
        checks++; if (bus.dc_cpu_wdata[15:8] !== 8'h22) begin errors++; $display("FAIL nomerge_data got=%h exp=22", bus.dc_cpu_wdata[15:8]); end
        drain();
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            store(4'hF, 32'h500 + 32'(4*i), 32'h50 + 32'(4*i));
        end
        @(negedge clk);
        store(4'hF, 32'h50C, 32'h5C);
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.dc_cpu_waddr !== 32'h504 + 32'(4*k)) begin errors++; $display("FAIL pp_order k=%0d got=%h exp=%h", k, bus.dc_cpu_waddr, 32'h504 + 32'(4*k)); end
            @(negedge clk);
        end
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL pp_count3 got=%h exp=0", bus.dc_cpu_wen); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            store(4'hF, 32'h700 + 32'(4*i), 32'h70 + 32'(i));
        end
        @(negedge clk);
        store(4'hF, 32'h714, 32'h75);
        bus.dc_dev_wrdy = 1'b1;
        @(negedge clk);
        store(4'h0, 32'h0, 32'h0);
        bus.dc_dev_wrdy = 1'b0;
        bus.lk_addr = 32'h700; #1;
        checks++; if (bus.lk_conflict !== 1'b1) begin errors++; $display("FAIL mid_pre_conflict got=%b exp=1", bus.lk_conflict); end
        checks++; if (bus.wb_idle !== 1'b0) begin errors++; $display("FAIL mid_pre_busy got=%b exp=0", bus.wb_idle); end
        checks++; if (bus.dc_cpu_waddr !== 32'h704) begin errors++; $display("FAIL mid_pre_head got=%h exp=704", bus.dc_cpu_waddr); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.cpu_wrdy !== 1'b1) begin errors++; $display("FAIL mid_rst_wrdy got=%b exp=1", bus.cpu_wrdy); end
        checks++; if (bus.dc_cpu_wen !== 4'h0) begin errors++; $display("FAIL mid_rst_wen got=%h exp=0", bus.dc_cpu_wen); end
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", bus.wb_idle); end
        checks++; if (bus.lk_conflict !== 1'b0) begin errors++; $display("FAIL mid_rst_conflict got=%b exp=0", bus.lk_conflict); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.wb_idle !== 1'b1) begin errors++; $display("FAIL mid_post_idle got=%b exp=1", bus.wb_idle); end
        checks++; if (bus.lk_conflict !== 1'b0) begin errors++; $display("FAIL mid_post_conflict got=%b exp=0", bus.lk_conflict); end
    endtask

    initial begin
        store(4'h0, 32'h0, 32'h0);
        bus.lk_addr     = 32'h0;
        bus.dc_dev_wrdy = 1'b0;
        test_reset();
        test_single();
        test_merge();
        test_full_wrap();
        test_conflict();
        test_no_merge_on_pop();
        test_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
